roulette_game_ctrl: RTL
=======================

ROULETTE_GAME_CTRL -- requirements
Module: roulette_game_ctrl

Interface
REQ-001 Parameters: DEBOUNCE_CYCLES (default 500000), button-stable cycles, 10 ms at 50 MHz.
REQ-002 Parameters: CREDIT_INIT (default 10), credits after reset.
REQ-003 Parameters: BET_COST (default 1), credits per spin.
REQ-004 Parameters: PAYOUT (default 8), credits added on win.
REQ-005 Parameters: RESULT_HOLD (default 100000000), cycles the win/lose indication is held (2 s).
REQ-006 Parameters: TIMEOUT_CYCLES (default 400000000), spin watchdog limit, used only under the Configuration macro.
REQ-007 Ports: clk  input  1  50 MHz system clock.
REQ-008 Ports: rst  input  1  asynchronous, active-high reset.
REQ-009 Ports: btn_spin  input  1  raw, asynchronous, bouncing spin button, active high.
REQ-010 Ports: bet_sw  input  3  player's chosen position 0..7.
REQ-011 Ports: pos  input  3  landing position from the roulette LED stage, valid when spin_done=1.
REQ-012 Ports: spin_done  input  1  1-cycle completion pulse from the roulette LED stage.
REQ-013 Ports: start  output  1  1-cycle pulse to the roulette LED stage.
REQ-014 Ports: credit  output  8  current credit balance.
REQ-015 Ports: win, lose  output  1 each  result flags, held for the whole RESULT state.
REQ-016 Ports: busy  output  1  high in SPIN and RESULT.
REQ-017 Ports: game_over  output  1  high in GAMEOVER.
REQ-018 Ports: timeout  output  1  1-cycle watchdog pulse.

Function
REQ-019 Input conditioning: btn_spin passes through a 2-flop synchronizer, then a debounce counter that updates the debounced level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-020 Press event: a press is the rising edge of the debounced level; falling edges and held levels generate nothing.
REQ-021 FSM states: IDLE, SPIN, RESULT, GAMEOVER.
REQ-022 IDLE, press with credit >= BET_COST: assert start for exactly one cycle, latch bet_sw, subtract BET_COST from credit in that same cycle, go to SPIN.
REQ-023 IDLE, press with credit < BET_COST: no start pulse, go to GAMEOVER.
REQ-024 SPIN, spin_done=1, pos equals the latched bet: set win, add PAYOUT to credit (saturating at 255), go to RESULT.
REQ-025 SPIN, spin_done=1, pos differs from the latched bet: set lose, credit unchanged, go to RESULT.
REQ-026 Bet changes: bet_sw changes after the latch point have no effect on the current spin.
REQ-027 SPIN, press: ignored; no second start pulse is ever issued while busy.
REQ-028 RESULT: hold win or lose for RESULT_HOLD cycles, then clear both flags, then go to IDLE if credit >= BET_COST, else GAMEOVER.
REQ-029 RESULT and GAMEOVER, press: ignored; GAMEOVER exits only via rst.
REQ-030 Stray completion: spin_done outside SPIN is ignored.
REQ-031 Simultaneous events: a press and spin_done in the same cycle in SPIN process only spin_done.
REQ-032 Output exclusivity: win and lose are never high together; start never coincides with busy=1 from a previous cycle.

Reset
REQ-033 rst=1 forces asynchronously: state=IDLE, credit=CREDIT_INIT, start=0, win=0, lose=0, busy=0, game_over=0, timeout=0, synchronizer and debounce counter cleared, debounced level=0.
REQ-034 Reset mid-spin abandons the spin with no refund; a spin_done arriving after reset release is ignored per REQ-030.

Configuration
REQ-035 SPIN_TIMEOUT_EN defined: a watchdog counts cycles in SPIN; on reaching TIMEOUT_CYCLES without spin_done, pulse timeout for one cycle, refund BET_COST (saturating), go to IDLE.
REQ-036 SPIN_TIMEOUT_EN undefined: no watchdog logic; timeout is tied to 0; SPIN waits indefinitely.

Verification
REQ-037 Scenario, bounce filtering: reset, then bounce btn_spin 5 times with pulses shorter than DEBOUNCE_CYCLES, then hold -> exactly one start pulse; credit 10 -> 9.
REQ-038 Scenario, win: bet_sw=3, spin, spin_done with pos=3 -> win=1 for RESULT_HOLD cycles; credit 9 -> 17; then IDLE.
REQ-039 Scenario, lose with stray inputs: bet_sw=3, spin, change bet_sw to 5, spin_done with pos=5 -> lose=1; credit stays 9; extra presses during SPIN/RESULT produce no start.
REQ-040 Scenario, exhaustion: CREDIT_INIT=1, spin and lose -> after RESULT, game_over=1; further presses produce no start; rst -> credit=1, state IDLE.
REQ-041 Scenario, saturation: credit=250, win with PAYOUT=8 -> credit=255.
REQ-042 Scenario, timeout (SPIN_TIMEOUT_EN, TIMEOUT_CYCLES=1000): spin with no spin_done -> timeout pulse at cycle 1000 of SPIN; credit restored to its pre-spin value; IDLE. Without the macro -> busy stays 1 and timeout stays 0.

Source files
------------

// File: rtl/roulette_game_if.sv
// Bundles the roulette controller's player, LED-stage and status signals.
// The controller binds the slave modport; whoever drives it (board top or bench) uses master.
interface roulette_game_if;
    logic       btn_spin;
    logic [2:0] bet_sw;
    logic [2:0] pos;
    logic       spin_done;
    logic       start;
    logic [7:0] credit;
    logic       win;
    logic       lose;
    logic       busy;
    logic       game_over;
    logic       timeout;

    modport master (
        output btn_spin, bet_sw, pos, spin_done,
        input  start, credit, win, lose, busy, game_over, timeout
    );

    modport slave (
        input  btn_spin, bet_sw, pos, spin_done,
        output start, credit, win, lose, busy, game_over, timeout
    );
endinterface

// File: rtl/roulette_game_ctrl.sv
// Roulette game controller: debounced spin button, credit bookkeeping, win/lose hold.
// Optional spin watchdog enabled by defining SPIN_TIMEOUT_EN.
module roulette_game_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CREDIT_INIT     = 10,
    parameter int BET_COST        = 1,
    parameter int PAYOUT          = 8,
    parameter int RESULT_HOLD     = 100000000,
    parameter int TIMEOUT_CYCLES  = 400000000
) (
    input  logic            clk,
    input  logic            rst,
    roulette_game_if.slave  bus
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(RESULT_HOLD + 1);

    typedef enum logic [1:0] {IDLE, SPIN, RESULT, GAMEOVER} state_t;

    // ---------------- button conditioning ----------------
    logic            sync1_reg, sync2_reg;
    logic            db_level_reg, db_level_d_reg;
    logic [DB_W-1:0] db_cnt_reg;
    logic            press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg      <= 1'b0;
            sync2_reg      <= 1'b0;
            db_level_reg   <= 1'b0;
            db_level_d_reg <= 1'b0;
            db_cnt_reg     <= '0;
        end else begin
            sync1_reg      <= bus.btn_spin;
            sync2_reg      <= sync1_reg;
            db_level_d_reg <= db_level_reg;
            // Any sample matching the current level restarts the stability count.
            if (sync2_reg == db_level_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level_reg <= sync2_reg;
                db_cnt_reg   <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
        end
    end

    assign press = db_level_reg & ~db_level_d_reg;

    // ---------------- game FSM ----------------
    state_t            state_reg, state_next;
    logic [7:0]        credit_reg, credit_next;
    logic [2:0]        bet_reg, bet_next;
    logic              start_reg, start_next;
    logic              win_reg, win_next;
    logic              lose_reg, lose_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

    logic       can_bet;
    logic [8:0] win_sum;
    logic [7:0] credit_won;

    assign can_bet    = ({1'b0, credit_reg} >= 9'(BET_COST));
    assign win_sum    = {1'b0, credit_reg} + 9'(PAYOUT);
    assign credit_won = win_sum[8] ? 8'hFF : win_sum[7:0];

`ifdef SPIN_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
    logic            timeout_reg, timeout_next;
    logic [8:0]      refund_sum;
    logic [7:0]      credit_refund;

    assign refund_sum    = {1'b0, credit_reg} + 9'(BET_COST);
    assign credit_refund = refund_sum[8] ? 8'hFF : refund_sum[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            wd_cnt_reg  <= wd_cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign bus.timeout = timeout_reg;
`else
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            credit_reg   <= 8'(CREDIT_INIT);
            bet_reg      <= '0;
            start_reg    <= 1'b0;
            win_reg      <= 1'b0;
            lose_reg     <= 1'b0;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            credit_reg   <= credit_next;
            bet_reg      <= bet_next;
            start_reg    <= start_next;
            win_reg      <= win_next;
            lose_reg     <= lose_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        credit_next   = credit_reg;
        bet_next      = bet_reg;
        start_next    = 1'b0;
        win_next      = win_reg;
        lose_next     = lose_reg;
        hold_cnt_next = hold_cnt_reg;
`ifdef SPIN_TIMEOUT_EN
        wd_cnt_next   = wd_cnt_reg;
        timeout_next  = 1'b0;
`endif
        unique case (state_reg)
            IDLE: begin
                if (press) begin
                    if (can_bet) begin
                        start_next  = 1'b1;
                        bet_next    = bus.bet_sw;
                        credit_next = credit_reg - 8'(BET_COST);
                        state_next  = SPIN;
`ifdef SPIN_TIMEOUT_EN
                        wd_cnt_next = '0;
`endif
                    end else begin
                        state_next = GAMEOVER;
                    end
                end
            end
            SPIN: begin
                // Completion wins over a coincident press: presses are never looked at here.
                if (bus.spin_done) begin
                    if (bus.pos == bet_reg) begin
                        win_next    = 1'b1;
                        credit_next = credit_won;
                    end else begin
                        lose_next = 1'b1;
                    end
                    hold_cnt_next = '0;
                    state_next    = RESULT;
                end
`ifdef SPIN_TIMEOUT_EN
                else if (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_next = 1'b1;
                    credit_next  = credit_refund;
                    state_next   = IDLE;
                end else begin
                    wd_cnt_next = wd_cnt_reg + 1'b1;
                end
`endif
            end
            RESULT: begin
                if (hold_cnt_reg == HOLD_W'(RESULT_HOLD - 1)) begin
                    win_next   = 1'b0;
                    lose_next  = 1'b0;
                    state_next = can_bet ? IDLE : GAMEOVER;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            GAMEOVER: begin
                state_next = GAMEOVER;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.start     = start_reg;
    assign bus.credit    = credit_reg;
    assign bus.win       = win_reg;
    assign bus.lose      = lose_reg;
    assign bus.busy      = (state_reg == SPIN) || (state_reg == RESULT);
    assign bus.game_over = (state_reg == GAMEOVER);

endmodule
